// File: rtl/mem_resp_queue_if.sv
// mem_resp_queue_if: bundle of the EX-side push port, the data_sram response port, the WB-side
// retire port and the ID forwarding ports of mem_resp_queue.
//
//   flush                     pipeline flush; drops every resident entry
//   in_*                      EX offers one instruction (valid/ready handshake)
//   data_ok / rdata           one in-order data_sram response
//   out_*                     head entry towards WB (valid/ready handshake)
//   rd_addr / fwd_*           NRD forwarding queries from ID
//   occupancy                 number of resident entries
//   cancel_pending            responses of flushed requests are still owed
//
// Modport slave is the queue itself; modport master is whatever drives it.
interface mem_resp_queue_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 64,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_need_resp;
    logic [1:0]        in_size;
    logic              in_signed;
    logic [1:0]        in_addr_lo;
    logic              in_is_load;
    logic [DW-1:0]     in_alu_result;
    logic [4:0]        in_dest;
    logic              in_gr_we;
    logic [TAGW-1:0]   in_payload;
    logic              data_ok;
    logic [DW-1:0]     rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_result;
    logic [4:0]        out_dest;
    logic              out_gr_we;
    logic [TAGW-1:0]   out_payload;
    logic [NRD*5-1:0]  rd_addr;
    logic [NRD-1:0]    fwd_hit;
    logic [NRD-1:0]    fwd_wait;
    logic [NRD*DW-1:0] fwd_data;
    logic [CntW-1:0]   occupancy;
    logic              cancel_pending;

    modport slave (
        input  flush, in_valid, in_need_resp, in_size, in_signed, in_addr_lo, in_is_load,
               in_alu_result, in_dest, in_gr_we, in_payload, data_ok, rdata, out_ready, rd_addr,
        output in_ready, out_valid, out_result, out_dest, out_gr_we, out_payload, fwd_hit,
               fwd_wait, fwd_data, occupancy, cancel_pending
    );

    modport master (
        output flush, in_valid, in_need_resp, in_size, in_signed, in_addr_lo, in_is_load,
               in_alu_result, in_dest, in_gr_we, in_payload, data_ok, rdata, out_ready, rd_addr,
        input  in_ready, out_valid, out_result, out_dest, out_gr_we, out_payload, fwd_hit,
               fwd_wait, fwd_data, occupancy, cancel_pending
    );
endinterface

// File: rtl/mem_resp_queue.sv
// mem_resp_queue: MEM stage between EX and WB. Holds up to DEPTH loads/stores/ALU results,
// matches in-order data_sram responses to the oldest entry still owed one, retires strictly in
// program order and forwards results of every resident entry to ID. Responses to requests
// dropped by a flush are counted in cancel_q and discarded as they arrive.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset (the external SRAM is reset together with it)
//   bus    mem_resp_queue_if.slave: push, response, retire and forwarding ports
//
// Build option: define MEMQ_LOAD_EXTRACT_EN to align and zero/sign-extend load data here;
// without it the raw rdata is the load result and extraction happens in WB.
module mem_resp_queue #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 64,
    parameter int unsigned NRD   = 2
) (
    input logic             clk,
    input logic             reset,
    mem_resp_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned CanW = $clog2(2 * DEPTH + 1);

    // Control state
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [CanW-1:0]  cancel_q, cancel_d;

    // Entry payload
    logic [DEPTH-1:0] need_q;
    logic [DEPTH-1:0] load_q;
    logic [DEPTH-1:0] we_q;
    logic [4:0]       dest_q    [DEPTH];
    logic [TAGW-1:0]  payload_q [DEPTH];
    logic [DW-1:0]    data_q    [DEPTH];

    logic            push, pop, complete;
    logic            resp_found;
    logic [PtrW-1:0] resp_idx;
    logic [CntW-1:0] pend_cnt;
    logic [CanW:0]   cancel_sum;
    logic [DW-1:0]   load_res;
    logic [PtrW-1:0] age_idx [DEPTH];

    // age_idx[0] is the oldest slot, age_idx[DEPTH-1] the youngest possible one.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign age_idx[g] = head_q + PtrW'(g);
    end

`ifdef MEMQ_LOAD_EXTRACT_EN
    logic [1:0] size_q [DEPTH];
    logic [1:0] alo_q  [DEPTH];
    logic [DEPTH-1:0] sgn_q;

    function automatic logic [DW-1:0] extract(input logic [DW-1:0] rd, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] alo);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] res;
        b = rd[8*int'(alo) +: 8];
        h = rd[16*int'(alo[1]) +: 16];
        case (size)
            2'd0:    res = {{(DW-8){sgn & b[7]}}, b};
            2'd1:    res = {{(DW-16){sgn & h[15]}}, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    assign load_res = extract(bus.rdata, size_q[resp_idx], sgn_q[resp_idx], alo_q[resp_idx]);

    always_ff @(posedge clk) begin
        if (push) begin
            size_q[tail_q] <= bus.in_size;
            alo_q[tail_q]  <= bus.in_addr_lo;
            sgn_q[tail_q]  <= bus.in_signed;
        end
    end
`else
    logic unused_extract_fields;
    assign unused_extract_fields = ^{bus.in_size, bus.in_signed, bus.in_addr_lo};
    assign load_res = bus.rdata;
`endif

    // Registered count: a full queue does not accept even if it retires this cycle.
    assign bus.in_ready = (count_q < CntW'(DEPTH)) & ~bus.flush;
    assign bus.out_valid = valid_q[head_q] & done_q[head_q] & ~bus.flush;
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    assign bus.out_result     = data_q[head_q];
    assign bus.out_dest       = dest_q[head_q];
    assign bus.out_gr_we      = we_q[head_q];
    assign bus.out_payload    = payload_q[head_q];
    assign bus.occupancy      = count_q;
    assign bus.cancel_pending = (cancel_q != '0);

    // Oldest entry still owed a response, and how many such entries there are.
    always_comb begin
        resp_found = 1'b0;
        resp_idx   = head_q;
        pend_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[age_idx[i]] && need_q[age_idx[i]] && !done_q[age_idx[i]]) begin
                pend_cnt = pend_cnt + CntW'(1);
                if (!resp_found) begin
                    resp_found = 1'b1;
                    resp_idx   = age_idx[i];
                end
            end
        end
    end

    // Response bookkeeping. On flush every owed response becomes a cancellation, less the one
    // arriving this cycle (it is consumed either by the counter or by the dropped entry).
    always_comb begin
        cancel_d   = cancel_q;
        complete   = 1'b0;
        cancel_sum = (CanW+1)'(cancel_q) + (CanW+1)'(pend_cnt);
        if (bus.flush) begin
            if (bus.data_ok && (cancel_sum != '0)) begin
                cancel_sum = cancel_sum - (CanW+1)'(1);
            end
            if (cancel_sum > (CanW+1)'(2 * DEPTH)) begin
                cancel_d = CanW'(2 * DEPTH);
            end else begin
                cancel_d = CanW'(cancel_sum);
            end
        end else if (bus.data_ok) begin
            if (cancel_q != '0) begin
                cancel_d = cancel_q - CanW'(1);
            end else if (resp_found) begin
                complete = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (complete) begin
                done_d[resp_idx] = 1'b1;
            end
            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PtrW'(1);
            end
            if (push) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = ~bus.in_need_resp;
                tail_d          = tail_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cancel_q <= '0;
        end else begin
            valid_q  <= valid_d;
            done_q   <= done_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            cancel_q <= cancel_d;
        end
    end

    // Push slot and completed slot never coincide: the completed entry is resident, the push
    // slot is free.
    always_ff @(posedge clk) begin
        if (push) begin
            need_q[tail_q]    <= bus.in_need_resp;
            load_q[tail_q]    <= bus.in_is_load;
            we_q[tail_q]      <= bus.in_gr_we;
            dest_q[tail_q]    <= bus.in_dest;
            payload_q[tail_q] <= bus.in_payload;
            data_q[tail_q]    <= bus.in_alu_result;
        end
        if (complete && load_q[resp_idx]) begin
            data_q[resp_idx] <= load_res;
        end
    end

    // Forwarding: scan oldest to youngest so the youngest match overrides older ones.
    logic [NRD-1:0]    fwd_hit, fwd_wait;
    logic [NRD*DW-1:0] fwd_data;

    always_comb begin
        fwd_hit  = '0;
        fwd_wait = '0;
        fwd_data = '0;
        for (int r = 0; r < NRD; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[age_idx[i]] && we_q[age_idx[i]] &&
                    (dest_q[age_idx[i]] == bus.rd_addr[r*5 +: 5]) &&
                    (bus.rd_addr[r*5 +: 5] != 5'd0)) begin
                    fwd_hit[r]          = 1'b1;
                    fwd_wait[r]         = ~done_q[age_idx[i]];
                    fwd_data[r*DW +: DW] = data_q[age_idx[i]];
                end
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit;
    assign bus.fwd_wait = fwd_wait;
    assign bus.fwd_data = fwd_data;

endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed bench for mem_resp_queue with the default parameters (DW 32, DEPTH 4, TAGW 64, NRD 2).
module tb_mem_resp_queue;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_resp_queue_if #(.DW(32), .DEPTH(4), .TAGW(64), .NRD(2)) bus ();

    mem_resp_queue #(.DW(32), .DEPTH(4), .TAGW(64), .NRD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic need, input logic is_load, input logic [1:0] size,
                        input logic sgn, input logic [1:0] alo, input logic [4:0] dest,
                        input logic [31:0] alu, input logic [63:0] payload);
        bus.in_valid      = 1'b1;
        bus.in_need_resp  = need;
        bus.in_is_load    = is_load;
        bus.in_size       = size;
        bus.in_signed     = sgn;
        bus.in_addr_lo    = alo;
        bus.in_dest       = dest;
        bus.in_gr_we      = 1'b1;
        bus.in_alu_result = alu;
        bus.in_payload    = payload;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] data);
        bus.data_ok = 1'b1;
        bus.rdata   = data;
        tick();
        bus.data_ok = 1'b0;
    endtask

    logic [31:0] exp_b, exp_h;
    logic [31:0] seq [4];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_need_resp = 1'b0;
        bus.in_size = 2'd0;
        bus.in_signed = 1'b0;
        bus.in_addr_lo = 2'd0;
        bus.in_is_load = 1'b0;
        bus.in_alu_result = '0;
        bus.in_dest = '0;
        bus.in_gr_we = 1'b0;
        bus.in_payload = '0;
        bus.data_ok = 1'b0;
        bus.rdata = '0;
        bus.out_ready = 1'b0;
        bus.rd_addr = {5'd0, 5'd5};
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_occ", 64'(bus.occupancy), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_cancel", 64'(bus.cancel_pending), 64'd0);
        check("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
        check("rst_fwd_wait", 64'(bus.fwd_wait), 64'd0);

        // 1: ld.b signed addr_lo=3, response two cycles after push
`ifdef MEMQ_LOAD_EXTRACT_EN
        exp_b = 32'hFFFF_FF80;
        exp_h = 32'h0000_8765;
`else
        exp_b = 32'h8000_0000;
        exp_h = 32'h8765_4321;
`endif
        push(1'b1, 1'b1, 2'd0, 1'b1, 2'd3, 5'd1, 32'h0, 64'hAAAA);
        check("t1_wait_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.data_ok = 1'b1;
        bus.rdata   = 32'h8000_0000;
        #1;
        check("t1_no_comb_path", 64'(bus.out_valid), 64'd0);
        tick();
        bus.data_ok = 1'b0;
        check("t1_valid", 64'(bus.out_valid), 64'd1);
        check("t1_result", 64'(bus.out_result), 64'(exp_b));
        check("t1_payload", bus.out_payload, 64'hAAAA);
        check("t1_dest", 64'(bus.out_dest), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t1_occ", 64'(bus.occupancy), 64'd0);
        // ld.hu addr_lo=2
        push(1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 5'd2, 32'h0, 64'h1);
        resp(32'h8765_4321);
        check("t1_half", 64'(bus.out_result), 64'(exp_h));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // 2: fill to DEPTH, then four responses retire in order
        seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'h33; seq[3] = 32'h44;
        for (int k = 0; k < 4; k++) begin
            push(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'(k + 1), 32'h0, 64'(k));
        end
        check("t2_full_occ", 64'(bus.occupancy), 64'd4);
        check("t2_full_ready", 64'(bus.in_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            resp(seq[k]);
        end
        // Full with a retire in the same cycle must not accept
        bus.in_valid      = 1'b1;
        bus.in_need_resp  = 1'b0;
        bus.in_is_load    = 1'b0;
        bus.in_alu_result = 32'hDEAD;
        bus.out_ready     = 1'b1;
        #1;
        check("t2_full_retire_ready", 64'(bus.in_ready), 64'd0);
        check("t2_ret0", 64'(bus.out_result), 64'(seq[0]));
        tick();
        bus.in_valid = 1'b0;
        check("t2_occ_after_pop", 64'(bus.occupancy), 64'd3);
        for (int k = 1; k < 4; k++) begin
            check("t2_ret_valid", 64'(bus.out_valid), 64'd1);
            check("t2_ret", 64'(bus.out_result), 64'(seq[k]));
            tick();
        end
        bus.out_ready = 1'b0;
        check("t2_empty", 64'(bus.occupancy), 64'd0);

        // 3: forwarding priority, young ALU r5 over older pending load r5
        push(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd5, 32'h0, 64'h0);
        bus.rd_addr = {5'd0, 5'd5};
        #1;
        check("t3_load_hit", 64'(bus.fwd_hit[0]), 64'd1);
        check("t3_load_wait", 64'(bus.fwd_wait[0]), 64'd1);
        push(1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 5'd5, 32'd7, 64'h0);
        check("t3_alu_hit", 64'(bus.fwd_hit[0]), 64'd1);
        check("t3_alu_wait", 64'(bus.fwd_wait[0]), 64'd0);
        check("t3_alu_data", 64'(bus.fwd_data[31:0]), 64'd7);
        check("t3_r0_nohit", 64'(bus.fwd_hit[1]), 64'd0);
        resp(32'h99);
        bus.out_ready = 1'b1;
        check("t3_ret_load", 64'(bus.out_result), 64'h99);
        tick();
        check("t3_ret_alu", 64'(bus.out_result), 64'd7);
        tick();
        bus.out_ready = 1'b0;
        check("t3_empty", 64'(bus.occupancy), 64'd0);

        // 4: flush with two loads owed and a data_ok in the same cycle
        push(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd6, 32'h0, 64'h0);
        push(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd7, 32'h0, 64'h0);
        bus.flush   = 1'b1;
        bus.data_ok = 1'b1;
        bus.rdata   = 32'hDEAD;
        #1;
        check("t4_flush_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.flush   = 1'b0;
        bus.data_ok = 1'b0;
        check("t4_occ", 64'(bus.occupancy), 64'd0);
        check("t4_cancel", 64'(bus.cancel_pending), 64'd1);
        push(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd8, 32'h0, 64'h4);
        resp(32'h0BAD);
        check("t4_discard_valid", 64'(bus.out_valid), 64'd0);
        check("t4_cancel_clear", 64'(bus.cancel_pending), 64'd0);
        resp(32'h5A5A_5A5A);
        check("t4_new_valid", 64'(bus.out_valid), 64'd1);
        check("t4_new_result", 64'(bus.out_result), 64'h5A5A_5A5A);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // 5: WB stall with head done
        push(1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 5'd9, 32'hCAFE, 64'h1234_5678_9ABC_DEF0);
        check("t5_latency", 64'(bus.out_valid), 64'd1);
        push(1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 5'd10, 32'hBEEF, 64'h2);
        for (int k = 0; k < 5; k++) begin
            check("t5_stall_result", 64'(bus.out_result), 64'hCAFE);
            check("t5_stall_payload", bus.out_payload, 64'h1234_5678_9ABC_DEF0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("t5_second", 64'(bus.out_result), 64'hBEEF);
        check("t5_second_valid", 64'(bus.out_valid), 64'd1);
        tick();
        bus.out_ready = 1'b0;
        check("t5_empty", 64'(bus.occupancy), 64'd0);

        // 6: reset with cancel_cnt=2 and 3 entries
        push(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd11, 32'h0, 64'h0);
        push(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd12, 32'h0, 64'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 5'd13, 32'(k), 64'h0);
        end
        check("t6_pre_occ", 64'(bus.occupancy), 64'd3);
        check("t6_pre_cancel", 64'(bus.cancel_pending), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_occ", 64'(bus.occupancy), 64'd0);
        check("t6_cancel", 64'(bus.cancel_pending), 64'd0);
        check("t6_out_valid", 64'(bus.out_valid), 64'd0);
        push(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 5'd14, 32'h0, 64'h0);
        resp(32'h77);
        check("t6_post_valid", 64'(bus.out_valid), 64'd1);
        check("t6_post_result", 64'(bus.out_result), 64'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
